// File: rtl/sfr_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sfr_wr_arbiter_pkg
// Shared definitions for the SFR write arbiter:
//   NREQ_DEFAULT    default number of write requesters
//   SFR_ACC         byte address of the accumulator SFR
//   ACC_BIT_PREFIX  upper five bits of every accumulator bit address
//   arb_state_t     arbiter FSM state encoding
//   is_acc_target   tells whether a write lands in the accumulator
// ---------------------------------------------------------------------------
package sfr_wr_arbiter_pkg;

    localparam int         NREQ_DEFAULT   = 3;
    localparam logic [7:0] SFR_ACC        = 8'hE0;
    localparam logic [4:0] ACC_BIT_PREFIX = 5'b11100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        SETTLE = 2'd2
    } arb_state_t;

    // A byte write hits ACC only at E0. A bit write hits ACC for bit
    // addresses E0..E7, so only the upper five bits are compared.
    function automatic logic is_acc_target(input logic [7:0] addr, input logic bit_wr);
        if (bit_wr) begin
            return (addr[7:3] == ACC_BIT_PREFIX);
        end
        return (addr == SFR_ACC);
    endfunction

endpackage

// File: rtl/sfr_wr_arbiter_arb_pick.sv
// ---------------------------------------------------------------------------
// sfr_arb_pick
// Combinational winner selection for the SFR write arbiter.
//   req     in  NREQ   pending write requests
//   ptr     in  PTR_W  last winner index (used only in round-robin mode)
//   winner  out NREQ   one-hot winner, all zero when nothing is requested
// SFR_RR_ARB_EN defined: round-robin, search starts at ptr+1 modulo NREQ.
// SFR_RR_ARB_EN undefined: fixed priority, lowest index wins.
// ---------------------------------------------------------------------------
module sfr_arb_pick
    import sfr_wr_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner
);

    logic found;

`ifdef SFR_RR_ARB_EN
    // Visit requesters in order ptr+1, ptr+2, ... wrapping at NREQ. Both
    // loops run over constants so every select has a fixed index.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
                    winner[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end
`else
    logic [PTR_W-1:0] unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sfr_wr_arbiter.sv
// ---------------------------------------------------------------------------
// sfr_wr_arbiter
// Arbitrates SFR write requests from NREQ requesters onto one SFR write port.
// A request seen in IDLE is latched into the output registers and strobed in
// the following WRITE cycle; writes to the accumulator get one extra SETTLE
// cycle so ACC parity settles before the next access.
//   clock            in   1        system clock
//   reset            in   1        asynchronous, active-high reset
//   req              in   NREQ     level write requests, held until done
//   req_addr         in   8*NREQ   byte/bit address, slice i = [8i+7:8i]
//   req_data         in   8*NREQ   byte write data, slice i = [8i+7:8i]
//   req_bit          in   NREQ     1 = bit write, 0 = byte write
//   req_bit_val      in   NREQ     bit value for a bit write
//   gnt              out  NREQ     one-hot grant during WRITE
//   done             out  NREQ     completion pulse, same cycle as gnt
//   sfr_addr         out  8        SFR address (held outside WRITE)
//   sfr_data         out  8        SFR byte data (held outside WRITE)
//   sfr_write_en     out  1        write strobe
//   sfr_write_bit_en out  1        strobe is a bit write
//   sfr_bit_in       out  1        bit value for a bit write
//   busy             out  1        FSM not in IDLE
// Build option: SFR_RR_ARB_EN selects round-robin instead of fixed priority.
// ---------------------------------------------------------------------------
module sfr_wr_arbiter
    import sfr_wr_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_bit,
    input  logic [NREQ-1:0]   req_bit_val,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        sfr_addr,
    output logic [7:0]        sfr_data,
    output logic              sfr_write_en,
    output logic              sfr_write_bit_en,
    output logic              sfr_bit_in,
    output logic              busy
);

    localparam int PTR_W = $clog2(NREQ);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [NREQ-1:0]  winner;
    logic [NREQ-1:0]  gnt_next;
    logic [7:0]       addr_next;
    logic [7:0]       data_next;
    logic             we_next;
    logic             wbe_next;
    logic             bit_next;
    logic             busy_next;
    logic [PTR_W-1:0] ptr;

    sfr_arb_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner)
    );

`ifdef SFR_RR_ARB_EN
    logic [PTR_W-1:0] ptr_next;

    // The pointer remembers the last winner and moves when a grant is taken.
    always_comb begin
        ptr_next = ptr;
        if (state == IDLE) begin
            for (int i = 0; i < NREQ; i++) begin
                if (winner[i]) begin
                    ptr_next = PTR_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= PTR_W'(NREQ - 1);
        end else begin
            ptr <= ptr_next;
        end
    end
`else
    assign ptr = PTR_W'(NREQ - 1);
`endif

    // Next-state and next-output logic. The SFR outputs double as the latched
    // transaction: they are loaded once in IDLE and only read afterwards, so
    // requester changes during WRITE/SETTLE cannot disturb them.
    always_comb begin
        state_next = state;
        gnt_next   = '0;
        addr_next  = sfr_addr;
        data_next  = sfr_data;
        we_next    = 1'b0;
        wbe_next   = 1'b0;
        bit_next   = sfr_bit_in;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = WRITE;
                    gnt_next   = winner;
                    we_next    = 1'b1;
                    wbe_next   = |(winner & req_bit);
                    bit_next   = |(winner & req_bit_val);
                    for (int i = 0; i < NREQ; i++) begin
                        if (winner[i]) begin
                            addr_next = req_addr[8*i +: 8];
                            data_next = req_data[8*i +: 8];
                        end
                    end
                end
            end
            WRITE: begin
                if (is_acc_target(sfr_addr, sfr_write_bit_en)) begin
                    state_next = SETTLE;
                end else begin
                    state_next = IDLE;
                end
            end
            SETTLE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            gnt              <= '0;
            done             <= '0;
            sfr_addr         <= 8'h00;
            sfr_data         <= 8'h00;
            sfr_write_en     <= 1'b0;
            sfr_write_bit_en <= 1'b0;
            sfr_bit_in       <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_next;
            gnt              <= gnt_next;
            done             <= gnt_next;
            sfr_addr         <= addr_next;
            sfr_data         <= data_next;
            sfr_write_en     <= we_next;
            sfr_write_bit_en <= wbe_next;
            sfr_bit_in       <= bit_next;
            busy             <= busy_next;
        end
    end

endmodule

// File: tb/tb_sfr_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sfr_wr_arbiter
// Directed bench for sfr_wr_arbiter (NREQ = 3). Expected SFR writes are queued
// when stimulus is issued; a monitor pops and compares on every strobe.
// Expected grant orders follow SFR_RR_ARB_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_sfr_wr_arbiter;

    typedef struct {
        logic [2:0] gnt;
        logic [7:0] addr;
        logic [7:0] data;
        logic       be;
        logic       bv;
        int         gap;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] req_addr;
    logic [23:0] req_data;
    logic [2:0]  req_bit;
    logic [2:0]  req_bit_val;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [7:0]  sfr_addr;
    logic [7:0]  sfr_data;
    logic        sfr_write_en;
    logic        sfr_write_bit_en;
    logic        sfr_bit_in;
    logic        busy;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   mon_cyc;
    int   mon_last;

    sfr_wr_arbiter #(.NREQ(3)) dut (
        .clock            (clock),
        .reset            (reset),
        .req              (req),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_bit          (req_bit),
        .req_bit_val      (req_bit_val),
        .gnt              (gnt),
        .done             (done),
        .sfr_addr         (sfr_addr),
        .sfr_data         (sfr_data),
        .sfr_write_en     (sfr_write_en),
        .sfr_write_bit_en (sfr_write_bit_en),
        .sfr_bit_in       (sfr_bit_in),
        .busy             (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, got no end expected end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushExp(input logic [2:0] g, input logic [7:0] a, input logic [7:0] d,
                           input logic be, input logic bv, input int gap);
        exp_t e;
        e.gnt  = g;
        e.addr = a;
        e.data = d;
        e.be   = be;
        e.bv   = bv;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic setReq(input int i, input logic [7:0] a, input logic [7:0] d,
                          input logic b, input logic bv);
        req_addr[8*i +: 8] = a;
        req_data[8*i +: 8] = d;
        req_bit[i]         = b;
        req_bit_val[i]     = bv;
    endtask

    // Raises the requests at a falling edge and then behaves like the
    // requesters: each drops its req when it sees its done, or, in hold mode,
    // all keep requesting until n_grants writes have completed.
    task automatic applyStimulus(input logic [2:0] r, input int n_grants, input bit hold);
        int got;
        int cycles;
        got    = 0;
        cycles = 0;
        req    = r;
        while (got < n_grants && cycles < 40) begin
            @(negedge clock);
            cycles++;
            if (done != 3'b000) begin
                got++;
                if (hold) begin
                    if (got == n_grants) req = 3'b000;
                end else begin
                    req = req & ~done;
                end
            end
        end
        req = 3'b000;
        checkOutput("grant_count", got, n_grants);
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued write;
    // between strobes no grant, done or bit strobe may appear.
    initial begin
        exp_t e;
        mon_cyc  = 0;
        mon_last = 0;
        forever begin
            @(negedge clock);
            mon_cyc++;
            if (sfr_write_en === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_strobe: got strobe gnt=0x%0h addr=0x%0h expected none",
                             gnt, sfr_addr);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_gnt", gnt, e.gnt);
                    checkOutput("sb_done", done, e.gnt);
                    checkOutput("sb_addr", sfr_addr, e.addr);
                    checkOutput("sb_data", sfr_data, e.data);
                    checkOutput("sb_bit_en", sfr_write_bit_en, e.be);
                    checkOutput("sb_bit_in", sfr_bit_in, e.bv);
                    checkOutput("sb_busy", busy, 1);
                    if (e.gap != 0) checkOutput("sb_spacing", mon_cyc - mon_last, e.gap);
                end
                mon_last = mon_cyc;
            end else begin
                checkOutput("idle_strobes", {gnt, done, sfr_write_bit_en}, 0);
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        req         = 3'b000;
        req_addr    = '0;
        req_data    = '0;
        req_bit     = 3'b000;
        req_bit_val = 3'b000;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_addr", sfr_addr, 8'h00);
        checkOutput("rst_data", sfr_data, 8'h00);
        checkOutput("rst_we", sfr_write_en, 0);
        checkOutput("rst_bit_in", sfr_bit_in, 0);

        $display("[TB] single byte write");
        setReq(0, 8'h90, 8'h5A, 1'b0, 1'b0);
        pushExp(3'b001, 8'h90, 8'h5A, 1'b0, 1'b0, 0);
        applyStimulus(3'b001, 1, 1'b0);
        @(negedge clock);
        checkOutput("t1_busy_after", busy, 0);
        checkOutput("t1_addr_hold", sfr_addr, 8'h90);
        checkOutput("t1_data_hold", sfr_data, 8'h5A);

        $display("[TB] simultaneous requests 1 and 2");
        setReq(1, 8'h91, 8'h11, 1'b0, 1'b0);
        setReq(2, 8'h92, 8'h22, 1'b0, 1'b0);
        pushExp(3'b010, 8'h91, 8'h11, 1'b0, 1'b0, 0);
        pushExp(3'b100, 8'h92, 8'h22, 1'b0, 1'b0, 2);
        applyStimulus(3'b110, 2, 1'b0);
        @(negedge clock);

        $display("[TB] all requests held");
        setReq(0, 8'hA0, 8'h10, 1'b0, 1'b0);
        setReq(1, 8'hA1, 8'h20, 1'b0, 1'b0);
        setReq(2, 8'hA2, 8'h30, 1'b0, 1'b0);
`ifdef SFR_RR_ARB_EN
        pushExp(3'b001, 8'hA0, 8'h10, 1'b0, 1'b0, 0);
        pushExp(3'b010, 8'hA1, 8'h20, 1'b0, 1'b0, 2);
        pushExp(3'b100, 8'hA2, 8'h30, 1'b0, 1'b0, 2);
        pushExp(3'b001, 8'hA0, 8'h10, 1'b0, 1'b0, 2);
`else
        for (int n = 0; n < 4; n++) begin
            pushExp(3'b001, 8'hA0, 8'h10, 1'b0, 1'b0, (n == 0) ? 0 : 2);
        end
`endif
        applyStimulus(3'b111, 4, 1'b1);
        @(negedge clock);

        $display("[TB] ACC bit write");
        setReq(0, 8'hE3, 8'hC3, 1'b1, 1'b1);
        pushExp(3'b001, 8'hE3, 8'hC3, 1'b1, 1'b1, 0);
        applyStimulus(3'b001, 1, 1'b0);
        @(negedge clock);
        checkOutput("t3_settle_busy", busy, 1);
        checkOutput("t3_settle_we", sfr_write_en, 0);
        @(negedge clock);
        checkOutput("t3_idle_busy", busy, 0);
        setReq(0, 8'h00, 8'h00, 1'b0, 1'b0);

        $display("[TB] ACC byte write spacing");
        setReq(0, 8'hE0, 8'h77, 1'b0, 1'b0);
        setReq(1, 8'h80, 8'h88, 1'b0, 1'b0);
`ifdef SFR_RR_ARB_EN
        pushExp(3'b010, 8'h80, 8'h88, 1'b0, 1'b0, 0);
        pushExp(3'b001, 8'hE0, 8'h77, 1'b0, 1'b0, 2);
`else
        pushExp(3'b001, 8'hE0, 8'h77, 1'b0, 1'b0, 0);
        pushExp(3'b010, 8'h80, 8'h88, 1'b0, 1'b0, 3);
`endif
        applyStimulus(3'b011, 2, 1'b0);
        repeat (2) @(negedge clock);

        $display("[TB] reset during SETTLE");
        setReq(0, 8'hE0, 8'h66, 1'b0, 1'b0);
        setReq(1, 8'h85, 8'h55, 1'b0, 1'b0);
        pushExp(3'b001, 8'hE0, 8'h66, 1'b0, 1'b0, 0);
        req = 3'b001;
        @(negedge clock);
        checkOutput("t6_done0", done, 3'b001);
        req = 3'b010;
        @(negedge clock);
        checkOutput("t6_settle_busy", busy, 1);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_addr", sfr_addr, 8'h00);
        checkOutput("t6_rst_data", sfr_data, 8'h00);
        checkOutput("t6_rst_gnt", {gnt, done}, 0);
        pushExp(3'b010, 8'h85, 8'h55, 1'b0, 1'b0, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("t6_strobe_after_release", sfr_write_en, 1);
        req = 3'b000;

        repeat (4) @(negedge clock);
        checkOutput("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sfr_wr_arbiter.md
SFR_WR_ARBITER -- requirements
Module: sfr_wr_arbiter

Interface
REQ-001 Parameter: NREQ, default 3, number of SFR write requesters (supported range 2..4).
REQ-002 Ports: clock  in  1  system clock. reset is the asynchronous, active-high reset; clock is the clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req  in  NREQ  per-requester write request, level, held until its done pulse.
REQ-005 req_addr  in  8*NREQ  per-requester SFR byte address or bit address; slice i = bits [8i+7:8i].
REQ-006 req_data  in  8*NREQ  per-requester byte write data.
REQ-007 req_bit  in  NREQ  1 = bit write, 0 = byte write.
REQ-008 req_bit_val  in  NREQ  bit value for a bit write.
REQ-009 gnt  out  NREQ  one-hot grant, high only during WRITE.
REQ-010 done  out  NREQ  one-cycle completion pulse, coincident with gnt.
REQ-011 sfr_addr  out  8  address to SFR file.
REQ-012 sfr_data  out  8  byte data to SFR file.
REQ-013 sfr_write_en  out  1  write strobe.
REQ-014 sfr_write_bit_en  out  1  qualifies strobe as bit write.
REQ-015 sfr_bit_in  out  1  bit value to SFR file.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, WRITE, SETTLE; all state and outputs registered.
REQ-018 IDLE: with any req bit high, arbitrate, latch winner's addr/data/bit/bit_val, go to WRITE next cycle; with no req, stay in IDLE.
REQ-019 WRITE lasts exactly one cycle: sfr_write_en=1, sfr_write_bit_en=latched bit, sfr_addr/sfr_data/sfr_bit_in=latched values, gnt[i]=done[i]=1 for the winner.
REQ-020 Request-to-strobe latency is 1 cycle: req seen in IDLE at edge N, strobe high in cycle N+1.
REQ-021 After WRITE, an accumulator target (byte write with addr==8'hE0, or bit write with addr[7:3]==5'b11100) goes to SETTLE for 1 cycle and then IDLE; any other target goes directly to IDLE.
REQ-022 SETTLE: no strobe, no grant; lets ACC parity settle before the next access.
REQ-023 Requester drops req in the cycle after done; a req still high when the FSM is in IDLE is treated as a new request, so back-to-back writes are legal.
REQ-024 Req changes while the FSM is in WRITE or SETTLE do not alter the latched transaction.
REQ-025 Without SFR_RR_ARB_EN, arbitration is fixed priority with lowest index winning.
REQ-026 Outside WRITE: sfr_write_en=0, sfr_write_bit_en=0, gnt=0, done=0; sfr_addr/sfr_data hold their last values.
REQ-027 Throughput: at most one write every 2 cycles (non-ACC) or every 3 cycles (ACC target).

Reset
REQ-028 Reset forces state=IDLE, gnt=0, done=0, sfr_write_en=0, sfr_write_bit_en=0, sfr_bit_in=0, sfr_addr=8'h00, sfr_data=8'h00, busy=0, RR pointer=NREQ-1.
REQ-029 Reset asserted during WRITE or SETTLE aborts the transaction immediately with no strobe and no done; after release, requests are re-arbitrated from IDLE.

Configuration
REQ-030 SFR_RR_ARB_EN defined: round-robin arbitration. The pointer holds the last winner; search starts at pointer+1 modulo NREQ; the pointer updates on entry to WRITE.
REQ-031 SFR_RR_ARB_EN undefined: fixed priority per REQ-025; no pointer register is built.

Structure
REQ-032 Shared package holds the SFR_ACC (8'hE0) constant, the ACC bit-address prefix 5'b11100, the FSM state encoding and the NREQ default.
REQ-033 One sub-module, sfr_arb_pick: combinational, takes the req vector and pointer, produces a one-hot winner. Fixed or round-robin mode is selected by the macro.

Verification
REQ-034 req=3'b001, addr0=8'h90, data0=8'h5A, byte write -> one cycle later strobe with sfr_addr=8'h90, sfr_data=8'h5A, gnt=done=3'b001; busy low the following cycle.
REQ-035 req=3'b110 simultaneously -> fixed mode grants index 1 then index 2; RR mode with pointer=1 grants index 2 first.
REQ-036 Bit write addr=8'hE3, bit_val=1 -> strobe with sfr_write_bit_en=1 and sfr_bit_in=1, then 1 SETTLE cycle with no strobe, then IDLE.
REQ-037 All three requests held high continuously in RR mode -> grants 0,1,2,0,... with non-ACC targets spaced 2 cycles apart.
REQ-038 Reset pulsed during SETTLE after an ACC write -> all outputs at reset values asynchronously; a pending req is granted 1 cycle after release plus arbitration.
